// File: rtl/ring_fifo_pkg.sv
// Shared FIFO definitions: full-policy selectors and the depth derivation
// used by every FIFO built on a power-of-two pointer width.
package ring_fifo_pkg;

   localparam int FIFO_DROP_NEWEST      = 0;
   localparam int FIFO_OVERWRITE_OLDEST = 1;

   function automatic int fifo_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/ring_fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one read port with a registered output.
// Read-before-write on a shared address; only the output register is reset, never the array.
module sdp_ram
   import ring_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] mem [fifo_depth(ADDR_W)];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   always_comb begin
      rd_data_d = rd_data_q;
      if (i_rd_en) rd_data_d = mem[i_rd_addr];
   end

   always_ff @(posedge i_clk) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/ring_fifo.sv
// Circular FIFO for the received-character path: level-counter based status, sticky
// over/underflow, flush, selectable full policy. 1-cycle read latency; all status registered.
module ring_fifo
   import ring_fifo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 10,
   parameter int AFULL_LVL = 1008,
   parameter int OVERWRITE = FIFO_DROP_NEWEST
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_flush,
   input  logic              i_wr_en,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_rd_en,
   output logic [DATA_W-1:0] o_data,
   output logic              o_rd_valid,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_almost_full,
   output logic [ADDR_W:0]   o_level,
   output logic              o_overflow,
   output logic              o_underflow
);

   localparam int              DEPTH     = fifo_depth(ADDR_W);
   localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_L   = (ADDR_W+1)'(AFULL_LVL);
   localparam logic            EVICT_EN  = (OVERWRITE == FIFO_OVERWRITE_OLDEST);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              afull_q, afull_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              rd_valid_q, rd_valid_d;

   logic pop_ok, wr_ok, evict, ram_wr_en, ram_rd_en;

   // A write to a full FIFO is a normal write when a pop frees the slot the same edge;
   // otherwise it is either dropped or, with eviction enabled, pushes the read pointer along.
   always_comb begin
      pop_ok = i_rd_en && !empty_q;
      wr_ok  = i_wr_en && (!full_q || i_rd_en);
      evict  = EVICT_EN && i_wr_en && full_q && !i_rd_en;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      rd_valid_d = 1'b0;

      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_ok || evict)  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         if (pop_ok || evict) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         if (wr_ok && !pop_ok)      level_d = level_q + (ADDR_W+1)'(1);
         else if (pop_ok && !wr_ok) level_d = level_q - (ADDR_W+1)'(1);
         if (i_wr_en && full_q && !i_rd_en) ovf_d = 1'b1;
         if (i_rd_en && empty_q)            udf_d = 1'b1;
         rd_valid_d = pop_ok;
      end

      empty_d = (level_d == '0);
      full_d  = (level_d == DEPTH_LVL);
      afull_d = (level_d >= AFULL_L);

      ram_wr_en = i_rst && !i_flush && (wr_ok || evict);
      ram_rd_en = !i_flush && pop_ok;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         afull_q    <= afull_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   sdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (ram_wr_en),
      .i_wr_addr (wr_ptr_q),
      .i_wr_data (i_data),
      .i_rd_en   (ram_rd_en),
      .i_rd_addr (rd_ptr_q),
      .o_rd_data (o_data)
   );

   assign o_rd_valid    = rd_valid_q;
   assign o_empty       = empty_q;
   assign o_full        = full_q;
   assign o_almost_full = afull_q;
   assign o_level       = level_q;
   assign o_overflow    = ovf_q;
   assign o_underflow   = udf_q;

endmodule

// File: tb/tb_ring_fifo.sv
// Directed bench for ring_fifo: drop-newest (u_d0) and overwrite-oldest (u_d1) instances
// share one stimulus stream; status vectors are {empty, full, almost_full, overflow, underflow}.
module tb_ring_fifo;

   logic       clk = 1'b0;
   logic       rst, flush, wr_en, rd_en;
   logic [7:0] data;

   logic [7:0]  d0_data, d1_data;
   logic        d0_vld, d1_vld, d0_empty, d1_empty, d0_full, d1_full;
   logic        d0_afull, d1_afull, d0_ovf, d1_ovf, d0_udf, d1_udf;
   logic [10:0] d0_level, d1_level;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ring_fifo #(.DATA_W(8), .ADDR_W(10), .AFULL_LVL(1008), .OVERWRITE(0)) u_d0 (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_data(data), .i_rd_en(rd_en),
      .o_data(d0_data), .o_rd_valid(d0_vld), .o_empty(d0_empty), .o_full(d0_full),
      .o_almost_full(d0_afull), .o_level(d0_level), .o_overflow(d0_ovf), .o_underflow(d0_udf));

   ring_fifo #(.DATA_W(8), .ADDR_W(10), .AFULL_LVL(1008), .OVERWRITE(1)) u_d1 (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_data(data), .i_rd_en(rd_en),
      .o_data(d1_data), .o_rd_valid(d1_vld), .o_empty(d1_empty), .o_full(d1_full),
      .o_almost_full(d1_afull), .o_level(d1_level), .o_overflow(d1_ovf), .o_underflow(d1_udf));

   wire [4:0] st0 = {d0_empty, d0_full, d0_afull, d0_ovf, d0_udf};
   wire [4:0] st1 = {d1_empty, d1_full, d1_afull, d1_ovf, d1_udf};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; data = 8'h00;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      repeat (3) step();
      rst = 1'b1;
   endtask

   task automatic fill(input int n, input int base);
      wr_en = 1'b1;
      for (int k = 0; k < n; k++) begin
         data = 8'(k + base);
         step();
      end
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (st0 !== 5'b10000) begin n_fail++; $display("FAIL reset_status0: got %b want 10000", st0); end
      n_checks++; if (st1 !== 5'b10000) begin n_fail++; $display("FAIL reset_status1: got %b want 10000", st1); end
      n_checks++; if (d0_level !== 11'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", d0_level); end
      n_checks++; if ({d0_vld, d0_data} !== 9'd0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", {d0_vld, d0_data}); end
   endtask

   task automatic test_fill_drain();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
      do_reset();
      fill(3, 'h41);
      n_checks++; if (d0_level !== 11'd3) begin n_fail++; $display("FAIL fd_level: got %0d want 3", d0_level); end
      rd_en = 1'b1;
      for (int j = 0; j < 3; j++) begin
         step();
         n_checks++;
         if ({d0_vld, d0_data} !== {1'b1, exp_b[j]}) begin
            n_fail++; $display("FAIL fd_pop%0d: got vld=%b data=%0h want vld=1 data=%0h", j, d0_vld, d0_data, exp_b[j]);
         end
      end
      rd_en = 1'b0;
      n_checks++; if (st0 !== 5'b10000) begin n_fail++; $display("FAIL fd_empty: got %b want 10000", st0); end
      step();
      n_checks++; if (d0_vld !== 1'b0) begin n_fail++; $display("FAIL fd_vld_pulse: got %b want 0", d0_vld); end
   endtask

   task automatic test_full_policy();
      logic [7:0] e1;
      do_reset();
      fill(1024, 0);
      n_checks++; if (st0 !== 5'b01100 || d0_level !== 11'd1024) begin n_fail++; $display("FAIL full_status0: got %b/%0d want 01100/1024", st0, d0_level); end
      wr_en = 1'b1; data = 8'hFF;
      step();
      wr_en = 1'b0;
      n_checks++; if (st0 !== 5'b01110 || d0_level !== 11'd1024) begin n_fail++; $display("FAIL ovf_status0: got %b/%0d want 01110/1024", st0, d0_level); end
      n_checks++; if (st1 !== 5'b01110 || d1_level !== 11'd1024) begin n_fail++; $display("FAIL ovf_status1: got %b/%0d want 01110/1024", st1, d1_level); end
      rd_en = 1'b1;
      for (int j = 0; j < 1024; j++) begin
         step();
         e1 = (j < 1023) ? 8'(j + 1) : 8'hFF;
         n_checks++; if (d0_data !== 8'(j)) begin n_fail++; $display("FAIL drop_drain%0d: got %0h want %0h", j, d0_data, 8'(j)); end
         n_checks++; if (d1_data !== e1) begin n_fail++; $display("FAIL ovw_drain%0d: got %0h want %0h", j, d1_data, e1); end
      end
      rd_en = 1'b0;
      n_checks++; if (d0_empty !== 1'b1 || d1_empty !== 1'b1) begin n_fail++; $display("FAIL full_drained: got %b%b want 11", d0_empty, d1_empty); end
   endtask

   task automatic test_full_concurrent();
      do_reset();
      fill(1024, 0);
      wr_en = 1'b1; rd_en = 1'b1; data = 8'hAA;
      step();
      idle();
      n_checks++; if ({d0_vld, d0_data, d0_level} !== {1'b1, 8'h00, 11'd1024}) begin n_fail++; $display("FAIL conc_pop0: got %b/%0h/%0d want 1/0/1024", d0_vld, d0_data, d0_level); end
      n_checks++; if ({d1_vld, d1_data, d1_level} !== {1'b1, 8'h00, 11'd1024}) begin n_fail++; $display("FAIL conc_pop1: got %b/%0h/%0d want 1/0/1024", d1_vld, d1_data, d1_level); end
      n_checks++; if (d0_ovf !== 1'b0 || d1_ovf !== 1'b0) begin n_fail++; $display("FAIL conc_noovf: got %b%b want 00", d0_ovf, d1_ovf); end
   endtask

   task automatic test_wrap();
      do_reset();
      wr_en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         data  = 8'(i);
         rd_en = (i >= 10);
         step();
         if (i >= 10) begin
            n_checks++;
            if (d0_level !== 11'd10 || d0_vld !== 1'b1 || d0_data !== 8'(i - 10)) begin
               n_fail++; $display("FAIL wrap%0d: got lvl=%0d vld=%b data=%0h want 10/1/%0h", i, d0_level, d0_vld, d0_data, 8'(i - 10));
            end
         end
      end
      wr_en = 1'b0; rd_en = 1'b1;
      for (int j = 0; j < 10; j++) begin
         step();
         n_checks++; if (d0_data !== 8'(1490 + j)) begin n_fail++; $display("FAIL wrap_tail%0d: got %0h want %0h", j, d0_data, 8'(1490 + j)); end
      end
      rd_en = 1'b0;
      n_checks++; if (st0 !== 5'b10000) begin n_fail++; $display("FAIL wrap_empty: got %b want 10000", st0); end
   endtask

   task automatic test_underflow();
      do_reset();
      rd_en = 1'b1; wr_en = 1'b1; data = 8'h5A;
      step();
      n_checks++; if (d0_udf !== 1'b1 || d0_vld !== 1'b0 || d0_level !== 11'd1) begin n_fail++; $display("FAIL udf: got udf=%b vld=%b lvl=%0d want 1/0/1", d0_udf, d0_vld, d0_level); end
      wr_en = 1'b0;
      step();
      rd_en = 1'b0;
      n_checks++; if ({d0_vld, d0_data, d0_level} !== {1'b1, 8'h5A, 11'd0}) begin n_fail++; $display("FAIL udf_then_pop: got %b/%0h/%0d want 1/5a/0", d0_vld, d0_data, d0_level); end
      n_checks++; if (st1 !== 5'b10001) begin n_fail++; $display("FAIL udf_sticky1: got %b want 10001", st1); end
   endtask

   task automatic test_flush_afull();
      do_reset();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      fill(501, 'h30);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      n_checks++; if (d0_level !== 11'd500 || d0_data !== 8'h30) begin n_fail++; $display("FAIL pre_flush: got %0d/%0h want 500/30", d0_level, d0_data); end
      flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data = 8'h77;
      step();
      idle();
      n_checks++; if (st0 !== 5'b10000 || d0_level !== 11'd0) begin n_fail++; $display("FAIL flush_status: got %b/%0d want 10000/0", st0, d0_level); end
      n_checks++; if (d0_vld !== 1'b0 || d0_data !== 8'h30) begin n_fail++; $display("FAIL flush_data_hold: got %b/%0h want 0/30", d0_vld, d0_data); end
      fill(1007, 0);
      n_checks++; if (d0_afull !== 1'b0 || d0_level !== 11'd1007) begin n_fail++; $display("FAIL afull_1007: got %b/%0d want 0/1007", d0_afull, d0_level); end
      fill(1, 0);
      n_checks++; if (st0 !== 5'b00100 || d0_level !== 11'd1008) begin n_fail++; $display("FAIL afull_1008: got %b/%0d want 00100/1008", st0, d0_level); end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      test_reset();
      test_fill_drain();
      test_full_policy();
      test_full_concurrent();
      test_wrap();
      test_underflow();
      test_flush_afull();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
